// File: rtl/clock_monitor_pkg.sv
// Shared definitions for the clock monitor: FSM encodings, synchronizer depth
// and a helper giving the all-ones value of a counter of a given width.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } cm_state_e;

  localparam int unsigned SYNC_DEPTH    = 2;
  // Edges are trusted only once the synchronizer and the edge-detect flop hold real samples.
  localparam int unsigned WARMUP_CYCLES = SYNC_DEPTH + 1;

  function automatic logic [31:0] sat_max(input int unsigned width);
    if (width >= 32) begin
      return 32'hFFFF_FFFF;
    end else begin
      return (32'd1 << width) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/clock_monitor_sync_2ff.sv
// Generic 1-bit two-flop synchronizer with synchronous active-high reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back capture flops for the asynchronous input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clock_monitor.sv
// Measures high time, low time and period of mon_clk_i in clk_i cycles and flags out-of-range periods.
// Optional stuck-clock detection is enabled by defining CLOCK_MONITOR_TIMEOUT_EN.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PERIOD_MIN = 4,
  parameter int unsigned PERIOD_MAX = 64,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mon_clk_i,
  input  logic             enable_i,
  input  logic             clr_err_i,
  output logic             meas_valid_o,
  output logic [CNT_W-1:0] high_cnt_o,
  output logic [CNT_W-1:0] low_cnt_o,
  output logic [CNT_W-1:0] period_cnt_o,
  output logic             err_range_o,
  output logic             err_stuck_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [1:0]       WARM_END = 2'(WARMUP_CYCLES);

  logic             mon_sync_s;
  logic             mon_prev_q;
  logic [1:0]       warm_q, warm_d;
  logic             edge_ok_s, rise_s, fall_s;
  cm_state_e        state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d, phase_inc_s;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             err_range_q, err_range_d;
  logic             publish_s;
  logic [CNT_W:0]   sum_s;
  logic [CNT_W-1:0] period_val_s;
  logic             period_sat_s, range_bad_s;
  logic             stuck_hit_s;

  sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (mon_clk_i),
    .q_o   (mon_sync_s)
  );

  assign edge_ok_s   = (warm_q == WARM_END);
  assign rise_s      = edge_ok_s & mon_sync_s & ~mon_prev_q;
  assign fall_s      = edge_ok_s & ~mon_sync_s & mon_prev_q;
  assign phase_inc_s = (phase_q == CNT_MAX) ? phase_q : (phase_q + CNT_ONE);

  // A period that carries out or lands on the all-ones value is treated as saturated, hence too long.
  assign sum_s        = {1'b0, high_q} + {1'b0, phase_q};
  assign period_val_s = sum_s[CNT_W] ? CNT_MAX : sum_s[CNT_W-1:0];
  assign period_sat_s = sum_s[CNT_W] | (sum_s[CNT_W-1:0] == CNT_MAX);
  assign range_bad_s  = period_sat_s ||
                        (32'(period_val_s) < PERIOD_MIN) ||
                        (32'(period_val_s) > PERIOD_MAX);

  // Warm-up counter saturates once the edge detector holds valid history.
  always_comb begin
    warm_d = warm_q;
    if (warm_q != WARM_END) begin
      warm_d = warm_q + 2'd1;
    end else begin
      warm_d = warm_q;
    end
  end

`ifdef CLOCK_MONITOR_TIMEOUT_EN
  localparam int unsigned     IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              err_stuck_q, err_stuck_d;

  // Idle counter: cleared by any synced edge, advances only while measuring.
  always_comb begin
    idle_d      = idle_q;
    stuck_hit_s = 1'b0;
    if (rise_s || fall_s) begin
      idle_d = '0;
    end else if (enable_i) begin
      if (idle_q == IDLE_LAST) begin
        stuck_hit_s = 1'b1;
        idle_d      = '0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end else begin
      idle_d = idle_q;
    end
    err_stuck_d = stuck_hit_s | (err_stuck_q & ~clr_err_i);
  end

  // Idle counter and sticky stuck flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_q      <= '0;
      err_stuck_q <= 1'b0;
    end else begin
      idle_q      <= idle_d;
      err_stuck_q <= err_stuck_d;
    end
  end

  assign err_stuck_o = err_stuck_q;
`else
  assign stuck_hit_s = 1'b0;
  assign err_stuck_o = 1'b0;
`endif

  // Next-state, phase counting and publish decision.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    high_d       = high_q;
    publish_s    = 1'b0;
    if (!enable_i || stuck_hit_s) begin
      state_d = WAIT_RISE;
    end else begin
      case (state_q)
        WAIT_RISE: begin
          if (rise_s) begin
            state_d = HIGH;
            phase_d = CNT_ONE;
          end else begin
            state_d = WAIT_RISE;
          end
        end
        HIGH: begin
          if (fall_s) begin
            state_d = LOW;
            high_d  = phase_q;
            phase_d = CNT_ONE;
          end else begin
            phase_d = phase_inc_s;
          end
        end
        LOW: begin
          if (rise_s) begin
            state_d   = HIGH;
            publish_s = 1'b1;
            phase_d   = CNT_ONE;
          end else begin
            phase_d = phase_inc_s;
          end
        end
        default: begin
          state_d = WAIT_RISE;
        end
      endcase
    end
  end

  // Output register next values; a new error in the clear cycle keeps the flag set.
  always_comb begin
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    period_cnt_d = period_cnt_q;
    meas_valid_d = 1'b0;
    if (publish_s) begin
      high_cnt_d   = high_q;
      low_cnt_d    = phase_q;
      period_cnt_d = period_val_s;
      meas_valid_d = 1'b1;
    end else begin
      meas_valid_d = 1'b0;
    end
    err_range_d = (publish_s & range_bad_s) | (err_range_q & ~clr_err_i);
  end

  // All measurement state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mon_prev_q   <= 1'b0;
      warm_q       <= 2'd0;
      state_q      <= WAIT_RISE;
      phase_q      <= '0;
      high_q       <= '0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      err_range_q  <= 1'b0;
    end else begin
      mon_prev_q   <= mon_sync_s;
      warm_q       <= warm_d;
      state_q      <= state_d;
      phase_q      <= phase_d;
      high_q       <= high_d;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      period_cnt_q <= period_cnt_d;
      meas_valid_q <= meas_valid_d;
      err_range_q  <= err_range_d;
    end
  end

  assign meas_valid_o = meas_valid_q;
  assign high_cnt_o   = high_cnt_q;
  assign low_cnt_o    = low_cnt_q;
  assign period_cnt_o = period_cnt_q;
  assign err_range_o  = err_range_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Directed self-checking bench for clock_monitor (default 16-bit instance plus a 4-bit saturation instance).
module tb_clock_monitor;

  logic        clk = 1'b0;
  logic        rst, mon, en, clr;
  logic        mv, er, es;
  logic [15:0] hc, lc, pc;
  logic        mv4, er4, es4;
  logic [3:0]  hc4, lc4, pc4;
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          lat    = 0;
  int          first  = 0;

  always #5 clk = ~clk;

  clock_monitor #(.CNT_W(16), .PERIOD_MIN(4), .PERIOD_MAX(64), .TIMEOUT(256)) dut (
    .clk_i(clk), .rst_i(rst), .mon_clk_i(mon), .enable_i(en), .clr_err_i(clr),
    .meas_valid_o(mv), .high_cnt_o(hc), .low_cnt_o(lc), .period_cnt_o(pc),
    .err_range_o(er), .err_stuck_o(es)
  );

  clock_monitor #(.CNT_W(4), .PERIOD_MIN(4), .PERIOD_MAX(64), .TIMEOUT(256)) dut4 (
    .clk_i(clk), .rst_i(rst), .mon_clk_i(mon), .enable_i(en), .clr_err_i(clr),
    .meas_valid_o(mv4), .high_cnt_o(hc4), .low_cnt_o(lc4), .period_cnt_o(pc4),
    .err_range_o(er4), .err_stuck_o(es4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mv) pulses++;
  endtask

  task automatic period(input int hi, input int lo);
    lat = 0;
    mon = 1'b1;
    for (int i = 1; i <= hi; i++) begin
      tick();
      if (mv && lat == 0) lat = i;
    end
    mon = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    rst = 1'b1; mon = 1'b0; en = 1'b1; clr = 1'b0;
    repeat (3) tick();
    chk("rst_mv", 32'(mv), 32'd0);
    chk("rst_period", 32'(pc), 32'd0);
    chk("rst_err", 32'({er, es}), 32'd0);
    rst = 1'b0;
    repeat (5) tick();

    // 1: 10/10 clock, first rise never publishes
    pulses = 0;
    repeat (5) period(10, 10);
    chk("t1_pulses", 32'(pulses), 32'd4);
    chk("t1_high", 32'(hc), 32'd10);
    chk("t1_low", 32'(lc), 32'd10);
    chk("t1_period", 32'(pc), 32'd20);
    chk("t1_err", 32'(er), 32'd0);

    // 2: 6/14 duty, publish 3 cycles after rise
    repeat (3) period(6, 14);
    chk("t2_high", 32'(hc), 32'd6);
    chk("t2_low", 32'(lc), 32'd14);
    chk("t2_period", 32'(pc), 32'd20);
    chk("t2_latency", 32'(lat), 32'd3);

    // 3: too-short period, clear coinciding with a bad publish
    repeat (4) period(2, 1);
    chk("t3_period", 32'(pc), 32'd3);
    chk("t3_err", 32'(er), 32'd1);
    mon = 1'b1;
    tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_setwins_mv", 32'(mv), 32'd1);
    chk("t3_setwins_err", 32'(er), 32'd1);
    mon = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_cleared", 32'(er), 32'd0);
    period(10, 10);
    chk("t3_min_period", 32'(pc), 32'd4);
    chk("t3_min_err", 32'(er), 32'd0);
    repeat (2) period(10, 10);
    chk("t3_back20", 32'(pc), 32'd20);

    // 4: upper boundary, then too long, and 4-bit saturation
    repeat (2) period(30, 34);
    chk("t4_max_period", 32'(pc), 32'd64);
    chk("t4_max_err", 32'(er), 32'd0);
    repeat (3) period(50, 50);
    chk("t4_period100", 32'(pc), 32'd100);
    chk("t4_err", 32'(er), 32'd1);
    chk("t4_w4_high", 32'(hc4), 32'd15);
    chk("t4_w4_low", 32'(lc4), 32'd15);
    chk("t4_w4_period", 32'(pc4), 32'd15);
    chk("t4_w4_err", 32'(er4), 32'd1);

    // 5: reset mid-HIGH, then enable drop mid-period
    mon = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_out", 32'({mv, er, es}), 32'd0);
    chk("t5_rst_high", 32'(hc), 32'd0);
    chk("t5_rst_low", 32'(lc), 32'd0);
    chk("t5_rst_period", 32'(pc), 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    mon = 1'b0;
    repeat (10) tick();
    pulses = 0;
    period(10, 10);
    chk("t5_partial", 32'(pulses), 32'd0);
    period(8, 12);
    chk("t5_first_full", 32'(pulses), 32'd1);
    chk("t5_first_period", 32'(pc), 32'd20);
    chk("t5_first_high", 32'(hc), 32'd10);
    mon = 1'b1;
    repeat (4) tick();
    pulses = 0;
    en = 1'b0;
    repeat (4) tick();
    mon = 1'b0;
    repeat (12) tick();
    mon = 1'b1;
    repeat (8) tick();
    mon = 1'b0;
    repeat (12) tick();
    chk("t5_dis_pulses", 32'(pulses), 32'd0);
    chk("t5_dis_high", 32'(hc), 32'd8);
    chk("t5_dis_low", 32'(lc), 32'd12);
    chk("t5_dis_period", 32'(pc), 32'd20);
    en = 1'b1;
    pulses = 0;
    period(10, 10);
    chk("t5_reen_discard", 32'(pulses), 32'd0);
    period(10, 10);
    chk("t5_reen_pulses", 32'(pulses), 32'd1);
    chk("t5_reen_high", 32'(hc), 32'd10);

    // 6: mon_clk stuck high for 300 cycles
    first = 0;
    mon = 1'b1;
    for (int t = 1; t <= 300; t++) begin
      tick();
      if (t == 4) pulses = 0;
      if (es && first == 0) first = t;
    end
    chk("t6_no_publish", 32'(pulses), 32'd0);
`ifdef CLOCK_MONITOR_TIMEOUT_EN
    chk("t6_stuck", 32'(es), 32'd1);
    chk("t6_stuck_time", 32'(first), 32'd259);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6_stuck_clr", 32'(es), 32'd0);
`else
    chk("t6_stuck_off", 32'(es), 32'd0);
    chk("t6_never", 32'(first), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
